observer_reset_sequencer: RTL and testbench

Consumes the single-bit software system-reset request driven by the Parameter_SYS_Reset output port and the PLL lock status. Produces three staged, active-low reset outputs for the observer/controller datapath: ADC front-end, observer core, and controller/PWM. The block guarantees a minimum reset hold time and an ordered, staggered release. A small read-only Avalon-MM slave lets the Nios II read sequencer state and count reset events.

---
 rtl/observer_reset_pkg.sv | 18 +
 rtl/observer_sync2.sv | 24 ++
 rtl/observer_reset_sequencer.sv | 129 ++++++++++++
 tb/tb_observer_reset_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/observer_reset_pkg.sv
// Shared encodings for the observer reset sequencer:
// FSM state codes, register addresses and status bit positions.
package observer_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STG1 = 2'd1,
    ST_STG2 = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;

  localparam int BIT_LOCKED = 4;
  localparam int BIT_REQ    = 5;

endpackage

// File: rtl/observer_sync2.sv
// Generic two-flop single-bit synchronizer,
// asynchronous active-low reset, clears to 0.
module observer_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/observer_reset_sequencer.sv
// Staged reset release for ADC, observer core and controller,
// with a read-only status/event-count slave for the Nios II.
module observer_reset_sequencer
  import observer_reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned STAGGER_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sys_reset_req,
  input  logic        pll_locked,
  input  logic [1:0]  address,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        adc_rst_n,
  output logic        obs_rst_n,
  output logic        ctrl_rst_n,
  output logic        seq_done
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STG_LAST  = 16'(STAGGER_CYCLES - 1);

  logic             req_q, req_d;
  logic             locked_s;
  logic             hold_cond;
  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             adc_q, adc_d;
  logic             obs_q, obs_d;
  logic             ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic             unused_cs;

  observer_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign req_d     = sys_reset_req;
  assign hold_cond = req_q | ~locked_s;
  assign unused_cs = chipselect;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    unique case (state_q)
      ST_HOLD: if (cnt_q == HOLD_LAST) begin
        state_d = ST_STG1;
        cnt_d   = '0;
      end
      ST_STG1: if (cnt_q == STG_LAST) begin
        state_d = ST_STG2;
        cnt_d   = '0;
      end
      ST_STG2: if (cnt_q == STG_LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: cnt_d = '0;
    endcase
    // abort wins over any advance in the same cycle
    if (hold_cond) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (state_q != ST_HOLD && state_d == ST_HOLD
        && rst_cnt_q != '1)
      rst_cnt_d = rst_cnt_q + CNT_W'(1);
  end

  // outputs decoded from next state so they land with it
  always_comb begin
    adc_d  = state_d != ST_HOLD;
    obs_d  = state_d == ST_STG2 || state_d == ST_RUN;
    ctrl_d = state_d == ST_RUN;
    done_d = ctrl_d && state_q != ST_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
      adc_q     <= 1'b0;
      obs_q     <= 1'b0;
      ctrl_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_cnt_q <= rst_cnt_d;
      adc_q     <= adc_d;
      obs_q     <= obs_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
    end
  end

  assign adc_rst_n  = adc_q;
  assign obs_rst_n  = obs_q;
  assign ctrl_rst_n = ctrl_q;
  assign seq_done   = done_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_STATUS: begin
        readdata[1:0]        = state_q;
        readdata[BIT_LOCKED] = locked_s;
        readdata[BIT_REQ]    = req_q;
      end
      ADDR_COUNT: readdata = 32'(rst_cnt_q);
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_observer_reset_sequencer.sv
// Self-checking bench: table rows push per-cycle expectations
// into a scoreboard that a negedge monitor pops and compares.
module tb_observer_reset_sequencer;

  localparam int H  = 8;
  localparam int S  = 4;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sys_reset_req;
  logic        pll_locked;
  logic [1:0]  address;
  logic        chipselect;
  logic [31:0] readdata;
  logic        adc_rst_n, obs_rst_n, ctrl_rst_n, seq_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        req;
    logic        lock;
    int          n;
    logic [3:0]  out;
    logic        chk;
    logic [1:0]  addr;
    logic [31:0] rd;
  } row_t;

  typedef struct {
    string       name;
    logic [3:0]  out;
    logic        chk;
    logic [31:0] rd;
  } exp_t;

  row_t tbl[$];
  exp_t sb[$];
  exp_t e;

  observer_reset_sequencer #(
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sys_reset_req (sys_reset_req),
    .pll_locked    (pll_locked),
    .address       (address),
    .chipselect    (chipselect),
    .readdata      (readdata),
    .adc_rst_n     (adc_rst_n),
    .obs_rst_n     (obs_rst_n),
    .ctrl_rst_n    (ctrl_rst_n),
    .seq_done      (seq_done)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({adc_rst_n, obs_rst_n, ctrl_rst_n, seq_done});
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.name, " outs"}, outs(), 32'(e.out));
      if (e.chk) cmp({e.name, " rd"}, readdata, e.rd);
    end
  end

  task automatic add(string nm, logic rq, logic lk, int n,
                     logic [3:0] o, logic ck = 1'b0,
                     logic [1:0] a = 2'd0, logic [31:0] rd = 32'd0);
    row_t r;
    r.name = nm; r.req = rq; r.lock = lk; r.n = n;
    r.out = o; r.chk = ck; r.addr = a; r.rd = rd;
    tbl.push_back(r);
  endtask

  // each row starts just after a negedge and ends after the
  // negedge that samples its last posedge
  task automatic run_tbl();
    exp_t x;
    foreach (tbl[k]) begin
      sys_reset_req = tbl[k].req;
      pll_locked    = tbl[k].lock;
      address       = tbl[k].addr;
      for (int i = 0; i < tbl[k].n; i++) begin
        x.name = $sformatf("%s[%0d]", tbl[k].name, i);
        x.out  = tbl[k].out;
        x.chk  = tbl[k].chk && (i == tbl[k].n - 1);
        x.rd   = tbl[k].rd;
        sb.push_back(x);
      end
      repeat (tbl[k].n) @(posedge clk);
      @(negedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic add_powerup(string p);
    add({p, "_hold"}, 0, 1, H + 1, 4'b0000);
    add({p, "_stg1"}, 0, 1, S, 4'b1000);
    add({p, "_stg2"}, 0, 1, S, 4'b1100);
    add({p, "_done"}, 0, 1, 1, 4'b1111);
    add({p, "_cnt"},  0, 1, 1, 4'b1110, 1, 2'd1, 32'h0);
    add({p, "_stat"}, 0, 1, 1, 4'b1110, 1, 2'd0, 32'h13);
  endtask

  initial begin
    reset_n       = 1'b0;
    sys_reset_req = 1'b0;
    pll_locked    = 1'b1;
    address       = 2'd0;
    chipselect    = 1'b1;
    #3;
    cmp("rst_outs", outs(), 32'h0);
    cmp("rst_stat", readdata, 32'h0);
    address = 2'd1;
    #1;
    cmp("rst_cnt", readdata, 32'h0);
    #8;
    reset_n = 1'b1;

    add_powerup("pwr");
    add("pwr_a2", 0, 1, 1, 4'b1110, 1, 2'd2, 32'h0);
    add("pwr_a3", 0, 1, 1, 4'b1110, 1, 2'd3, 32'h0);
    run_tbl();

    add("sw_rise",  1, 1, 1, 4'b1110);
    add("sw_hold",  1, 1, 19, 4'b0000, 1, 2'd0, 32'h30);
    add("sw_rel",   0, 1, H, 4'b0000);
    add("sw_stg1",  0, 1, S, 4'b1000);
    add("sw_stg2",  0, 1, S, 4'b1100);
    add("sw_done",  0, 1, 1, 4'b1111);
    add("sw_run",   0, 1, 1, 4'b1110, 1, 2'd1, 32'd1);
    run_tbl();

    add("gl_rise",  1, 1, 1, 4'b1110);
    add("gl_hold",  0, 1, H, 4'b0000);
    add("gl_stg1",  0, 1, S, 4'b1000);
    add("gl_stg2",  0, 1, 2, 4'b1100, 1, 2'd1, 32'd2);
    run_tbl();

    add("pll_drop", 0, 0, 1, 4'b1100);
    add("pll_sync", 0, 1, 1, 4'b1100, 1, 2'd0, 32'h02);
    add("pll_hold", 0, 1, H, 4'b0000);
    add("pll_stg1", 0, 1, S, 4'b1000);
    add("pll_stg2", 0, 1, S, 4'b1100);
    add("pll_done", 0, 1, 1, 4'b1111);
    add("pll_run",  0, 1, 1, 4'b1110, 1, 2'd1, 32'd3);
    run_tbl();

    add("mh_rise",  1, 1, 1, 4'b1110);
    add("mh_cnt",   0, 1, 7, 4'b0000);
    add("mh_pulse", 1, 1, 1, 4'b0000, 1, 2'd0, 32'h30);
    add("mh_again", 0, 1, H, 4'b0000);
    add("mh_stg1",  0, 1, S, 4'b1000);
    add("mh_stg2",  0, 1, S, 4'b1100);
    add("mh_done",  0, 1, 1, 4'b1111);
    add("mh_run",   0, 1, 1, 4'b1110, 1, 2'd1, 32'd3);
    run_tbl();

    add("sat_rise", 1, 1, 1, 4'b1110);
    add("sat_hold", 0, 1, H, 4'b0000, 1, 2'd1, 32'd3);
    add("ar_stg1",  0, 1, 2, 4'b1000, 1, 2'd0, 32'h11);
    run_tbl();

    reset_n = 1'b0;
    #1;
    cmp("ar_outs", outs(), 32'h0);
    address = 2'd1;
    #1;
    cmp("ar_cnt", readdata, 32'h0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    add_powerup("pwr2");
    run_tbl();

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(negedge clk);
    cmp("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
